prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
Parametrised fetch/sequencing unit for the next-generation core. It owns the program counter, a writable jump-target LUT and the req/done handshake. It replaces fixed PC/LUT logic and the hard-wired "PC==128" done test with multi-program start selection, halt-opcode detection, stall support and a cycle watchdog. It sits between the host handshake and the instruction ROM/control decoder.

Parameters:
D, 12, program counter width
W, 9, instruction width
L, 5, LUT index width (2^L entries of D bits)
P, 2, program-select width (program k starts at LUT[k])
R, 6, relative-jump offset width (two's complement)
C, 16, cycle counter width
HALT_CODE, 9'h1FF, instruction value that ends a program (W bits)
TIMEOUT, 16'hFFFF, RUN-cycle limit before forced done

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-high
req  in  1  start request; rising edge accepted in IDLE/HALT
prog_sel  in  P  program to start; sampled with accepted req
mach_code  in  W  current instruction from instruction ROM
stall  in  1  hold PC and all state this cycle
absjump_en  in  1  jump to LUT[jump_idx]
jump_idx  in  L  LUT index for absolute jump
reljump_en  in  1  PC <= PC + sext(rel_off)
rel_off  in  R  signed relative offset
lut_we  in  1  LUT write enable
lut_waddr  in  L  LUT write index
lut_wdata  in  D  LUT write data
prog_ctr  out  D  current PC to instruction ROM
fetch_valid  out  1  high while in RUN
done  out  1  program finished (halt or timeout)
timeout  out  1  done was caused by watchdog
cycle_cnt  out  C  RUN cycles of current/last program, incl. stalls

Behaviour:
- Async reset: state=IDLE, prog_ctr=0, done=0, timeout=0, cycle_cnt=0, req_q=0, all LUT entries=0.
- req_q registers req each cycle; accept = req & ~req_q (rising edge). Holding req high starts exactly one run.
- States: IDLE, RUN, HALT. fetch_valid = (state==RUN), combinational from state.
- IDLE/HALT + accept: prog_ctr<=LUT[zero-ext prog_sel], cycle_cnt<=0, done<=0, timeout<=0, state<=RUN. Without accept, all outputs hold (done stays set in HALT).
- RUN, every cycle: cycle_cnt increments, saturating at all-ones (counts stall cycles too).
- RUN, stall=1: prog_ctr and state hold; no halt/jump evaluation. Watchdog still evaluated.
- RUN, stall=0, priority: (1) mach_code==HALT_CODE -> state<=HALT, done<=1, prog_ctr holds; (2) absjump_en -> prog_ctr<=LUT[jump_idx]; (3) reljump_en -> prog_ctr<=prog_ctr+sext(rel_off); (4) prog_ctr<=prog_ctr+1.
- PC arithmetic mod 2^D; wrap from all-ones to 0 and negative offsets below 0 wrap silently.
- Watchdog: in RUN, if cycle_cnt==TIMEOUT-1 at a clock edge and no halt is taken that cycle -> state<=HALT, done<=1, timeout<=1. Halt in the same cycle wins (timeout=0).
- req edges during RUN are ignored (req_q still tracks).
- LUT: synchronous write at edge when lut_we; reads are combinational and return the pre-write value in the write cycle. Writes are allowed in any state.
- done is registered: rises one cycle after the halt instruction is presented, held until the next accepted req.
- reset mid-RUN returns to IDLE immediately; LUT contents are lost.

Test Plan:
- Reset, write LUT[1]=12'h020, pulse req with prog_sel=1 -> next cycle prog_ctr=0x020, fetch_valid=1, done=0; with NOP code, PC counts 0x021, 0x022...
- In RUN at PC=0x025, drive mach_code=9'h1FF -> next edge done=1, timeout=0, prog_ctr stays 0x025, fetch_valid=0, cycle_cnt=6.
- At PC=0x010, set absjump_en=1 with jump_idx=3 (LUT[3]=0x100) and reljump_en=1 with rel_off=-2 -> PC=0x100 (abs wins). Then rel only with rel_off=6'h3E at PC=0x001 -> PC=0xFFF (wrap).
- stall=1 for 3 cycles at PC=0x030 with HALT_CODE on mach_code -> PC holds 0x030, done stays 0, cycle_cnt +3. Stall release -> done=1.
- Override TIMEOUT=8, run NOP loop -> done=1, timeout=1 after 8 RUN cycles. Hold req high throughout -> no restart; drop then raise req -> new run, done=0, cycle_cnt=0.
- Assert reset mid-RUN at PC=0x044 -> prog_ctr=0, done=0, state IDLE within the same cycle (async). Then lut_we to LUT[0]=0x055 in the same cycle as req (prog_sel=0) -> start PC=0x000 (old value).

Source files
------------

// File: rtl/prog_sequencer.sv
// Fetch/sequencing unit: program counter, writable jump-target LUT, req/done handshake,
// halt-opcode detection, stall support and a RUN-cycle watchdog.
module prog_sequencer #(
  parameter int             D         = 12,
  parameter int             W         = 9,
  parameter int             L         = 5,
  parameter int             P         = 2,
  parameter int             R         = 6,
  parameter int             C         = 16,
  parameter logic [W-1:0]   HALT_CODE = 9'h1FF,
  parameter logic [C-1:0]   TIMEOUT   = 16'hFFFF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic [P-1:0] prog_sel,
  input  logic [W-1:0] mach_code,
  input  logic         stall,
  input  logic         absjump_en,
  input  logic [L-1:0] jump_idx,
  input  logic         reljump_en,
  input  logic [R-1:0] rel_off,
  input  logic         lut_we,
  input  logic [L-1:0] lut_waddr,
  input  logic [D-1:0] lut_wdata,
  output logic [D-1:0] prog_ctr,
  output logic         fetch_valid,
  output logic         done,
  output logic         timeout,
  output logic [C-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  localparam logic [C-1:0] WD_LAST = TIMEOUT - {{(C-1){1'b0}}, 1'b1};

  state_e         state_q;
  logic           req_q;
  logic           done_q;
  logic           timeout_q;
  logic [D-1:0]   prog_ctr_q;
  logic [C-1:0]   cycle_cnt_q;
  logic [D-1:0]   lut_q [2**L];

  logic           accept_s;
  logic           halt_s;
  logic [L-1:0]   start_idx_s;
  logic [D-1:0]   rel_ext_s;
  logic [D-1:0]   prog_ctr_d;
  logic [C-1:0]   cycle_cnt_d;

  assign accept_s    = req & ~req_q;
  assign halt_s      = (mach_code == HALT_CODE) && !stall;
  assign start_idx_s = {{(L-P){1'b0}}, prog_sel};
  assign rel_ext_s   = {{(D-R){rel_off[R-1]}}, rel_off};

  always_comb begin
    prog_ctr_d  = prog_ctr_q + {{(D-1){1'b0}}, 1'b1};
    cycle_cnt_d = cycle_cnt_q;
    if (absjump_en) begin
      prog_ctr_d = lut_q[jump_idx];
    end else if (reljump_en) begin
      prog_ctr_d = prog_ctr_q + rel_ext_s;
    end else begin
      prog_ctr_d = prog_ctr_q + {{(D-1){1'b0}}, 1'b1};
    end
    // Saturate rather than wrap so a long run never reports a small count.
    if (&cycle_cnt_q) begin
      cycle_cnt_d = cycle_cnt_q;
    end else begin
      cycle_cnt_d = cycle_cnt_q + {{(C-1){1'b0}}, 1'b1};
    end
  end

  // Jump-target LUT: reads see the pre-write contents during a write cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**L; i++) begin
        lut_q[i] <= '0;
      end
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      prog_ctr_q  <= '0;
      cycle_cnt_q <= '0;
    end else begin
      req_q <= req;
      case (state_q)
        S_RUN: begin
          cycle_cnt_q <= cycle_cnt_d;
          if (halt_s) begin
            state_q <= S_HALT;
            done_q  <= 1'b1;
          end else begin
            if (!stall) begin
              prog_ctr_q <= prog_ctr_d;
            end
            // Watchdog fires on the TIMEOUT-th RUN cycle; a halt in that cycle wins.
            if (cycle_cnt_q == WD_LAST) begin
              state_q   <= S_HALT;
              done_q    <= 1'b1;
              timeout_q <= 1'b1;
            end
          end
        end
        default: begin
          if (accept_s) begin
            state_q     <= S_RUN;
            prog_ctr_q  <= lut_q[start_idx_s];
            cycle_cnt_q <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign prog_ctr    = prog_ctr_q;
  assign fetch_valid = (state_q == S_RUN);
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_cnt   = cycle_cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: directed scenarios plus randomized cycles, all checked
// against a cycle-level behavioural model of the sequencing rules.
module tb_prog_sequencer;

  localparam int TO = 8;
  localparam int HALT = 'h1FF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  prog_sel = '0;
  logic [8:0]  mach_code = '0;
  logic        stall = 1'b0;
  logic        absjump_en = 1'b0;
  logic [4:0]  jump_idx = '0;
  logic        reljump_en = 1'b0;
  logic [5:0]  rel_off = '0;
  logic        lut_we = 1'b0;
  logic [4:0]  lut_waddr = '0;
  logic [11:0] lut_wdata = '0;
  logic [11:0] prog_ctr;
  logic        fetch_valid;
  logic        done;
  logic        timeout;
  logic [15:0] cycle_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int m_lut [32];
  int m_pc, m_cnt;
  bit m_run, m_done, m_to, m_reqp;

  prog_sequencer #(.TIMEOUT(16'd8)) dut (
    .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel), .mach_code(mach_code),
    .stall(stall), .absjump_en(absjump_en), .jump_idx(jump_idx), .reljump_en(reljump_en),
    .rel_off(rel_off), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .prog_ctr(prog_ctr), .fetch_valid(fetch_valid), .done(done), .timeout(timeout),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  function automatic int wrap_pc(int v);
    return ((v % 4096) + 4096) % 4096;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_lut[i] = 0;
    m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0; m_to = 0; m_reqp = 0;
  endfunction

  // One clock edge of the sequencing rules, using the inputs currently driven.
  function automatic void model_step();
    int off;
    bit acc;
    acc = req && !m_reqp;
    if (m_run) begin
      int old_cnt;
      old_cnt = m_cnt;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (!stall && mach_code == HALT) begin
        m_run = 0; m_done = 1;
      end else begin
        if (!stall) begin
          off = rel_off;
          if (off >= 32) off = off - 64;
          if (absjump_en)      m_pc = m_lut[jump_idx];
          else if (reljump_en) m_pc = wrap_pc(m_pc + off);
          else                 m_pc = wrap_pc(m_pc + 1);
        end
        if (old_cnt == TO - 1) begin
          m_run = 0; m_done = 1; m_to = 1;
        end
      end
    end else if (acc) begin
      m_pc = m_lut[prog_sel]; m_cnt = 0; m_done = 0; m_to = 0; m_run = 1;
    end
    if (lut_we) m_lut[lut_waddr] = lut_wdata;
    m_reqp = req;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},      {20'd0, prog_ctr},    m_pc);
    chk({tag, ".valid"},   {31'd0, fetch_valid}, {31'd0, m_run});
    chk({tag, ".done"},    {31'd0, done},        {31'd0, m_done});
    chk({tag, ".timeout"}, {31'd0, timeout},     {31'd0, m_to});
    chk({tag, ".cnt"},     {16'd0, cycle_cnt},   m_cnt);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic lut_write(input logic [4:0] a, input logic [11:0] d);
    lut_we = 1'b1; lut_waddr = a; lut_wdata = d;
    tick("lutwr");
    lut_we = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b1;
    #2;
    check_all("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic start and NOP counting
    lut_write(5'd1, 12'h020);
    lut_write(5'd3, 12'h100);
    lut_write(5'd2, 12'h010);
    lut_write(5'd4, 12'h001);
    req = 1'b1; prog_sel = 2'd1; mach_code = 9'h000;
    tick("start");
    chk("start_pc", {20'd0, prog_ctr}, 32'h020);
    chk("start_valid", {31'd0, fetch_valid}, 32'd1);
    req = 1'b0;
    for (int i = 0; i < 5; i++) tick("nop");
    chk("nop_pc", {20'd0, prog_ctr}, 32'h025);
    mach_code = 9'h1FF;
    tick("halt");
    chk("halt_pc", {20'd0, prog_ctr}, 32'h025);
    chk("halt_done", {31'd0, done}, 32'd1);
    chk("halt_cnt", {16'd0, cycle_cnt}, 32'd6);
    tick("halt_hold");
    mach_code = 9'h000;

    // Jump priority and PC wrap
    req = 1'b1; prog_sel = 2'd2;
    tick("jstart");
    req = 1'b0;
    absjump_en = 1'b1; jump_idx = 5'd3; reljump_en = 1'b1; rel_off = 6'h3E;
    tick("abs_wins");
    chk("abs_pc", {20'd0, prog_ctr}, 32'h100);
    jump_idx = 5'd4; reljump_en = 1'b0;
    tick("abs_only");
    absjump_en = 1'b0; reljump_en = 1'b1; rel_off = 6'h3E;
    tick("rel_wrap");
    chk("rel_wrap_pc", {20'd0, prog_ctr}, 32'hFFF);
    reljump_en = 1'b0;
    tick("inc_wrap");
    chk("inc_wrap_pc", {20'd0, prog_ctr}, 32'h000);
    mach_code = 9'h1FF;
    tick("jhalt");
    mach_code = 9'h000;

    // Stall over a pending halt
    lut_write(5'd2, 12'h030);
    req = 1'b1; prog_sel = 2'd2;
    tick("sstart");
    req = 1'b0; mach_code = 9'h1FF; stall = 1'b1;
    for (int i = 0; i < 3; i++) tick("stall");
    chk("stall_pc", {20'd0, prog_ctr}, 32'h030);
    chk("stall_done", {31'd0, done}, 32'd0);
    chk("stall_cnt", {16'd0, cycle_cnt}, 32'd3);
    stall = 1'b0;
    tick("stall_rel");
    chk("stall_rel_done", {31'd0, done}, 32'd1);
    mach_code = 9'h000;

    // Watchdog with req held high throughout
    req = 1'b1; prog_sel = 2'd1;
    tick("wstart");
    for (int i = 0; i < 8; i++) tick("wrun");
    chk("wd_done", {31'd0, done}, 32'd1);
    chk("wd_timeout", {31'd0, timeout}, 32'd1);
    for (int i = 0; i < 3; i++) tick("wd_hold");
    chk("wd_no_restart", {31'd0, fetch_valid}, 32'd0);
    req = 1'b0;
    tick("wd_drop");
    req = 1'b1;
    tick("wd_restart");
    chk("restart_done", {31'd0, done}, 32'd0);
    chk("restart_cnt", {16'd0, cycle_cnt}, 32'd0);
    req = 1'b0;
    mach_code = 9'h1FF;
    tick("rhalt");
    mach_code = 9'h000;

    // Async reset mid-run, then LUT write racing the start
    lut_write(5'd3, 12'h044);
    req = 1'b1; prog_sel = 2'd3;
    tick("rstart");
    req = 1'b0;
    chk("pre_reset_pc", {20'd0, prog_ctr}, 32'h044);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_rst_pc", {20'd0, prog_ctr}, 32'h000);
    @(posedge clk); #1;
    reset = 1'b0;
    lut_we = 1'b1; lut_waddr = 5'd0; lut_wdata = 12'h055; req = 1'b1; prog_sel = 2'd0;
    tick("wr_start");
    chk("wr_start_pc", {20'd0, prog_ctr}, 32'h000);
    lut_we = 1'b0; req = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = ~req;
      prog_sel   = 2'($urandom_range(0, 3));
      mach_code  = ($urandom_range(0, 11) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
      stall      = ($urandom_range(0, 3) == 0);
      absjump_en = ($urandom_range(0, 5) == 0);
      jump_idx   = 5'($urandom_range(0, 31));
      reljump_en = ($urandom_range(0, 3) == 0);
      rel_off    = 6'($urandom_range(0, 63));
      lut_we     = ($urandom_range(0, 3) == 0);
      lut_waddr  = 5'($urandom_range(0, 31));
      lut_wdata  = 12'($urandom_range(0, 4095));
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
